// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W.
// Pipeline: input capture, twiddle multiply, add/sub, then scale/saturate,
// so a result emerges three en-high edges after its operands were sampled.
module fft_butterfly_r2 #(
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int SCALE_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] b_q,
    input  logic [TW_W-1:0]   w_i,
    input  logic [TW_W-1:0]   w_q,
    input  logic              tw_bypass,
    input  logic              inverse,
    input  logic              scale,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] y0_i,
    output logic [DATA_W-1:0] y0_q,
    output logic [DATA_W-1:0] y1_i,
    output logic [DATA_W-1:0] y1_q,
    output logic              valid_out,
    output logic              ovf
);

    // Full product width, product-sum width, internal datapath width.
    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;
    localparam int XW = DATA_W + 2;

    localparam logic signed [TW_W-1:0] W_MAX = {1'b0, {(TW_W-1){1'b1}}};
    localparam logic signed [TW_W-1:0] W_MIN = {1'b1, {(TW_W-1){1'b0}}};
    localparam logic signed [SW-1:0]   RND   = SW'(1) << (TW_W - 2);
    localparam logic signed [XW-1:0]   Y_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0]   Y_MIN = ~Y_MAX;
    localparam logic                   SCALE_OK = (SCALE_EN != 0);

    // Round half-up divide by two.
    function automatic logic signed [XW-1:0] halve(input logic signed [XW-1:0] x);
        logic signed [XW-1:0] t;
        t = x + XW'(1);
        return t >>> 1;
    endfunction

    function automatic logic out_of_range(input logic signed [XW-1:0] x);
        return (x > Y_MAX) || (x < Y_MIN);
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [XW-1:0] x);
        logic [DATA_W-1:0] r;
        if (x > Y_MAX)
            r = Y_MAX[DATA_W-1:0];
        else if (x < Y_MIN)
            r = Y_MIN[DATA_W-1:0];
        else
            r = x[DATA_W-1:0];
        return r;
    endfunction

    // ---------------- stage 0: input capture ----------------
    logic                     in_v;
    logic signed [DATA_W-1:0] in_a_i, in_a_q, in_b_i, in_b_q;
    logic signed [TW_W-1:0]   in_w_i, in_w_q;
    logic                     in_byp, in_inv, in_scl;

    // Capture operands together with their mode bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v   <= 1'b0;
            in_a_i <= '0;
            in_a_q <= '0;
            in_b_i <= '0;
            in_b_q <= '0;
            in_w_i <= '0;
            in_w_q <= '0;
            in_byp <= 1'b0;
            in_inv <= 1'b0;
            in_scl <= 1'b0;
        end else if (en) begin
            in_v   <= valid_in;
            in_a_i <= a_i;
            in_a_q <= a_q;
            in_b_i <= b_i;
            in_b_q <= b_q;
            in_w_i <= w_i;
            in_w_q <= w_q;
            in_byp <= tw_bypass;
            in_inv <= inverse;
            in_scl <= scale;
        end
    end

    // ---------------- stage 1: P = B * W' ----------------
    logic signed [TW_W-1:0] w_q_eff;
    logic signed [PW-1:0]   prod_ii, prod_qq, prod_iq, prod_qi;
    logic signed [SW-1:0]   p_i_rnd, p_q_rnd;
    logic signed [XW-1:0]   p_i_next, p_q_next;
    logic                   unused_bits;

    // Conjugate (with saturated negation), multiply, round and rescale.
    always_comb begin
        w_q_eff = in_w_q;
        if (in_inv)
            w_q_eff = (in_w_q == W_MIN) ? W_MAX : -in_w_q;
        prod_ii = PW'(in_b_i) * PW'(in_w_i);
        prod_qq = PW'(in_b_q) * PW'(w_q_eff);
        prod_iq = PW'(in_b_i) * PW'(w_q_eff);
        prod_qi = PW'(in_b_q) * PW'(in_w_i);
        p_i_rnd = SW'(prod_ii) - SW'(prod_qq) + RND;
        p_q_rnd = SW'(prod_iq) + SW'(prod_qi) + RND;
        // Slicing at TW_W-1 is the arithmetic shift; the top bits fit in XW.
        p_i_next = p_i_rnd[TW_W-1 +: XW];
        p_q_next = p_q_rnd[TW_W-1 +: XW];
        if (in_byp) begin
            p_i_next = XW'(in_b_i);
            p_q_next = XW'(in_b_q);
        end
    end

    assign unused_bits = ^{p_i_rnd[TW_W-2:0], p_q_rnd[TW_W-2:0]};

    logic                     s1_v, s1_scl;
    logic signed [DATA_W-1:0] s1_a_i, s1_a_q;
    logic signed [XW-1:0]     s1_p_i, s1_p_q;

    // Register the twiddled product alongside A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_scl <= 1'b0;
            s1_a_i <= '0;
            s1_a_q <= '0;
            s1_p_i <= '0;
            s1_p_q <= '0;
        end else if (en) begin
            s1_v   <= in_v;
            s1_scl <= in_scl;
            s1_a_i <= in_a_i;
            s1_a_q <= in_a_q;
            s1_p_i <= p_i_next;
            s1_p_q <= p_q_next;
        end
    end

    // ---------------- stage 2: add / subtract ----------------
    logic                 s2_v, s2_scl;
    logic signed [XW-1:0] s2_s0_i, s2_s0_q, s2_s1_i, s2_s1_q;

    // Butterfly sums; XW bits cannot overflow for any operand values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_scl  <= 1'b0;
            s2_s0_i <= '0;
            s2_s0_q <= '0;
            s2_s1_i <= '0;
            s2_s1_q <= '0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_scl  <= s1_scl;
            s2_s0_i <= XW'(s1_a_i) + s1_p_i;
            s2_s0_q <= XW'(s1_a_q) + s1_p_q;
            s2_s1_i <= XW'(s1_a_i) - s1_p_i;
            s2_s1_q <= XW'(s1_a_q) - s1_p_q;
        end
    end

    // ---------------- stage 3: scale and saturate ----------------
    logic                 do_scale;
    logic signed [XW-1:0] r0_i, r0_q, r1_i, r1_q;
    logic                 any_sat, sat_set;

    // Optional divide-by-two, then range check of all four results.
    always_comb begin
        do_scale = SCALE_OK && s2_scl;
        r0_i = do_scale ? halve(s2_s0_i) : s2_s0_i;
        r0_q = do_scale ? halve(s2_s0_q) : s2_s0_q;
        r1_i = do_scale ? halve(s2_s1_i) : s2_s1_i;
        r1_q = do_scale ? halve(s2_s1_q) : s2_s1_q;
        any_sat = out_of_range(r0_i) || out_of_range(r0_q) ||
                  out_of_range(r1_i) || out_of_range(r1_q);
        sat_set = en && s2_v && any_sat;
    end

    // Output register: clamped results and their valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_i      <= '0;
            y0_q      <= '0;
            y1_i      <= '0;
            y1_q      <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            y0_i      <= clamp(r0_i);
            y0_q      <= clamp(r0_q);
            y1_i      <= clamp(r1_i);
            y1_q      <= clamp(r1_q);
            valid_out <= s2_v;
        end
    end

    // Sticky overflow: a new saturation beats a simultaneous clear; clear ignores en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (sat_set)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2 with a queue-based scoreboard.
module tb_fft_butterfly_r2;

    localparam int DW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n, en, valid_in, tw_bypass, inverse, scale, ovf_clr;
    logic [DW-1:0] a_i, a_q, b_i, b_q;
    logic [TW-1:0] w_i, w_q;
    logic [DW-1:0] y0_i, y0_q, y1_i, y1_q;
    logic          valid_out, ovf;

    always #5 clk = ~clk;

    fft_butterfly_r2 #(.DATA_W(DW), .TW_W(TW), .SCALE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .w_i(w_i), .w_q(w_q),
        .tw_bypass(tw_bypass), .inverse(inverse), .scale(scale), .ovf_clr(ovf_clr),
        .y0_i(y0_i), .y0_q(y0_q), .y1_i(y1_i), .y1_q(y1_q),
        .valid_out(valid_out), .ovf(ovf)
    );

    typedef struct {
        int y0i, y0q, y1i, y1q;
        bit sat;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   total = 0;
    int   bad = 0;
    int   en_edges = 0;
    bit   m_ovf = 1'b0;
    bit   m_vout = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        return (n >= 0) ? n / d : -((-n + d - 1) / d);
    endfunction

    function automatic int clip(input longint x, inout bit s);
        if (x > 32767) begin s = 1'b1; return 32767; end
        if (x < -32768) begin s = 1'b1; return -32768; end
        return int'(x);
    endfunction

    function automatic exp_t model(input int ai, aq, bi, bq, wi, wq, input bit byp, inv, scl);
        exp_t   e;
        longint pi, pq, wqe, s0i, s0q, s1i, s1q;
        bit     s = 1'b0;
        if (byp) begin
            pi = bi;
            pq = bq;
        end else begin
            wqe = inv ? ((wq == -32768) ? 32767 : -wq) : wq;
            pi = floor_div(longint'(bi) * wi - longint'(bq) * wqe + 16384, 32768);
            pq = floor_div(longint'(bi) * wqe + longint'(bq) * wi + 16384, 32768);
        end
        s0i = ai + pi; s0q = aq + pq; s1i = ai - pi; s1q = aq - pq;
        if (scl) begin
            s0i = floor_div(s0i + 1, 2); s0q = floor_div(s0q + 1, 2);
            s1i = floor_div(s1i + 1, 2); s1q = floor_div(s1q + 1, 2);
        end
        e.y0i = clip(s0i, s); e.y0q = clip(s0q, s);
        e.y1i = clip(s1i, s); e.y1q = clip(s1q, s);
        e.sat = s;
        e.due = 0;
        return e;
    endfunction

    task automatic chk_y(input string pfx, input exp_t e);
        chk({pfx, "_y0i"}, $signed(y0_i), e.y0i);
        chk({pfx, "_y0q"}, $signed(y0_q), e.y0q);
        chk({pfx, "_y1i"}, $signed(y1_i), e.y1i);
        chk({pfx, "_y1q"}, $signed(y1_q), e.y1q);
    endtask

    // One clock: push expectation if sampled, then check after the edge.
    task automatic tick();
        exp_t e;
        bit   exp_v;
        if (en && valid_in) begin
            e = model($signed(a_i), $signed(a_q), $signed(b_i), $signed(b_q),
                      $signed(w_i), $signed(w_q), tw_bypass, inverse, scale);
            e.due = en_edges + 4;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (en) begin
            en_edges++;
            exp_v = (sb.size() > 0) && (sb[0].due == en_edges);
            chk("valid_out", valid_out, exp_v);
            if (exp_v) begin
                e = sb.pop_front();
                chk_y("res", e);
                last = e;
                m_vout = 1'b1;
                if (e.sat) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
            end else begin
                m_vout = 1'b0;
                if (ovf_clr) m_ovf = 1'b0;
            end
        end else begin
            chk("stall_valid", valid_out, m_vout);
            if (m_vout) chk_y("stall", last);
            if (ovf_clr) m_ovf = 1'b0;
        end
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic drive(input bit v, input int ai, aq, bi, bq, wi, wq, input bit byp, inv, scl);
        valid_in = v;
        a_i = DW'(ai); a_q = DW'(aq); b_i = DW'(bi); b_q = DW'(bq);
        w_i = TW'(wi); w_q = TW'(wq);
        tw_bypass = byp; inverse = inv; scale = scl;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_y0i"}, y0_i, 0);
        chk({tag, "_y0q"}, y0_q, 0);
        chk({tag, "_y1i"}, y1_i, 0);
        chk({tag, "_y1q"}, y1_q, 0);
        chk({tag, "_vout"}, valid_out, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; valid_in = 1'b0; ovf_clr = 1'b0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0; w_i = '0; w_q = '0;
        tw_bypass = 1'b0; inverse = 1'b0; scale = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass add/sub
        drive(1'b1, 100, 50, 20, 10, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(4);
        // Scaling with rounding
        drive(1'b1, 101, -3, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        idle(4);
        // Saturation, sticky hold, clear
        drive(1'b1, 32767, 0, 32767, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(5);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        idle(1);
        // Clear coincident with a new saturation: set wins
        drive(1'b1, -32768, 0, -32768, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        idle(1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;

        // Twiddle with min w_q, forward and inverse, back to back
        drive(1'b1, 0, 0, 1000, 0, 0, -32768, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 0, 0, 1000, 0, 0, -32768, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Assorted twiddled operands with random modes
        for (int i = 0; i < 6; i++)
            drive(1'b1, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                  1'b0, 1'(i & 1), 1'((i >> 1) & 1));
        idle(4);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;

        // Streaming with a 2-cycle stall mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                en = 1'b0; tick(); tick(); en = 1'b1;
            end
            drive(1'b1, 10 * i, -5 * i, 3 * i + 1, 7 - i, 23170, -23170, 1'b0, 1'b0, 1'(i & 1));
        end
        idle(4);

        // Reset with two operands in flight
        drive(1'b1, 5, 6, 7, 8, 0, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 9, 10, 11, 12, 0, 0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        sb.delete();
        m_vout = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        drive(1'b1, -200, 300, 50, -60, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Bounded drain: nothing may remain outstanding
        for (int k = 0; k < 8 && sb.size() > 0; k++) idle(1);
        chk("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_r2.md
FFT_BUTTERFLY_R2 -- requirements
Module: fft_butterfly_r2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed I/Q sample width.
REQ-002 The block SHALL have parameter TW_W, default 16, meaning signed twiddle width, format Q1.(TW_W-1).
REQ-003 The block SHALL have parameter SCALE_EN, default 1, meaning 1 = scale input honoured, 0 = scale forced off.
REQ-004 Port clk  input  1  clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  pipeline advance; 0 freezes every register.
REQ-007 Port valid_in  input  1  input operands valid this cycle.
REQ-008 Ports a_i, a_q, b_i, b_q  input  DATA_W each  butterfly operands A and B, signed.
REQ-009 Ports w_i, w_q  input  TW_W each  twiddle, signed.
REQ-010 Port tw_bypass  input  1  1 = twiddle taken as exactly 1+0j; w_i/w_q ignored.
REQ-011 Port inverse  input  1  1 = conjugated twiddle (IFFT).
REQ-012 Port scale  input  1  1 = divide both outputs by 2.
REQ-013 Port ovf_clr  input  1  clears sticky overflow flag.
REQ-014 Ports y0_i, y0_q, y1_i, y1_q  output  DATA_W each  results Y0 = A + B*W, Y1 = A - B*W.
REQ-015 Port valid_out  output  1  results valid.
REQ-016 Port ovf  output  1  sticky saturation flag.

Function
REQ-017 The pipeline SHALL be 3 stages; valid_out SHALL assert exactly 3 en-high rising edges after the edge that sampled valid_in=1.
REQ-018 Mode inputs (tw_bypass, inverse, scale) SHALL be sampled with the operands and carried down the pipeline with them.
REQ-019 Stage 1: W' = conj(W) if inverse; negation of w_q = -2^(TW_W-1) SHALL saturate to 2^(TW_W-1)-1.
REQ-020 Stage 1: P = B*W' with four full-precision products (DATA_W+TW_W bits), combined as P_i = b_i*w_i - b_q*w_q, P_q = b_i*w_q + b_q*w_i.
REQ-021 Stage 1: P SHALL be rounded half-up by adding 2^(TW_W-2) and arithmetic-shifting right TW_W-1, kept in DATA_W+2 bits; with tw_bypass, P = B exactly (sign-extended).
REQ-022 Stage 2: S0 = A + P, S1 = A - P, each DATA_W+2 bits, no overflow possible.
REQ-023 Stage 3: when scale=1 and SCALE_EN=1, S SHALL be rounded half-up (add 1, arithmetic shift right 1); otherwise unshifted.
REQ-024 Stage 3: each of the four results SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 Any saturation on a valid_out=1 cycle SHALL set ovf on the same edge that presents the result; ovf SHALL stay 1 until ovf_clr=1.
REQ-026 ovf_clr and a new saturation on the same edge: set SHALL win (ovf stays 1).
REQ-027 en=0 SHALL hold all data registers, valid flags, and outputs unchanged; ovf_clr SHALL act regardless of en.
REQ-028 valid_in=0 with en=1 SHALL insert a bubble: valid_out=0 three cycles later; data outputs may change but are don't-care.
REQ-029 Back-to-back valid_in=1 SHALL give one result per cycle with no stall.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all pipeline registers, all valid flags, y0_*, y1_*, valid_out, and ovf to 0.
REQ-031 Operands in flight at reset SHALL be discarded; no valid_out pulse SHALL emerge from them after rst_n returns to 1.
REQ-032 The first edge with rst_n=1 SHALL be able to sample valid_in.

Verification (DATA_W=16, TW_W=16, SCALE_EN=1, en=1 unless stated)
REQ-033 Bypass add/sub: A=(100,50), B=(20,10), tw_bypass=1, scale=0 -> 3 cycles later Y0=(120,60), Y1=(80,40), valid_out=1 for one cycle, ovf=0.
REQ-034 Scaling rounding: A=(101,-3), B=(0,0), tw_bypass=1, scale=1 -> Y0=Y1=(51,-1).
REQ-035 Saturation: A=(32767,0), B=(32767,0), tw_bypass=1, scale=0 -> Y0=(32767,0), Y1=(0,0), ovf=1 and held; ovf_clr pulse -> ovf=0; ovf_clr coincident with new saturation -> ovf=1.
REQ-036 Twiddle/inverse: A=(0,0), B=(1000,0), W=(0,-32768), inverse=0 -> Y0=(0,-1000), Y1=(0,1000); same with inverse=1 -> Y0=(0,1000), Y1=(0,-1000).
REQ-037 Streaming/stall: 8 consecutive valid inputs, en=0 for 2 cycles mid-stream -> 8 results in order, valid_out held during stall, total latency 3+2 cycles for stalled items.
REQ-038 Reset mid-operation: 2 valid operands in flight, rst_n=0 for 1 cycle -> all outputs 0 immediately, no valid_out pulse after release, next input completes normally in 3 cycles.
